// File: rtl/graph_mem_arbiter_if.sv
// Bundle between the graph fetch units, the memory read port and the graph_mem_arbiter.
// When MEM_ARB_PERF_EN is defined the bundle also carries the per-requester accept counters.
interface graph_mem_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]            req_valid_in;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in;
   logic [NUM_REQ-1:0]            req_ready_out;
   logic [NUM_REQ-1:0]            rsp_valid_out;
   logic [DATA_WIDTH-1:0]         rsp_data_out;
   logic                          mem_valid_out;
   logic [ADDR_WIDTH-1:0]         mem_addr_out;
   logic                          mem_valid_in;
   logic [DATA_WIDTH-1:0]         mem_data_in;
   logic                          proto_err_out;
`ifdef MEM_ARB_PERF_EN
   logic [NUM_REQ*16-1:0]         grant_count_out;

   modport slave (
      input  req_valid_in, req_addr_in, mem_valid_in, mem_data_in,
      output req_ready_out, rsp_valid_out, rsp_data_out, mem_valid_out, mem_addr_out,
      output proto_err_out, grant_count_out
   );
   modport master (
      output req_valid_in, req_addr_in, mem_valid_in, mem_data_in,
      input  req_ready_out, rsp_valid_out, rsp_data_out, mem_valid_out, mem_addr_out,
      input  proto_err_out, grant_count_out
   );
`else
   modport slave (
      input  req_valid_in, req_addr_in, mem_valid_in, mem_data_in,
      output req_ready_out, rsp_valid_out, rsp_data_out, mem_valid_out, mem_addr_out,
      output proto_err_out
   );
   modport master (
      output req_valid_in, req_addr_in, mem_valid_in, mem_data_in,
      input  req_ready_out, rsp_valid_out, rsp_data_out, mem_valid_out, mem_addr_out,
      input  proto_err_out
   );
`endif
endinterface

// File: rtl/graph_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency graph-memory read port, with tag-based response routing.
// Optional MEM_ARB_PERF_EN adds saturating per-requester 16-bit accept counters (grant_count_out).
module graph_mem_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 2
) (
   input  logic               clk_in,
   input  logic               rst_in,
   graph_mem_arbiter_if.slave bus
);
   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int GUARD_W = $clog2(READ_LATENCY + 1);
   localparam int TAIL    = READ_LATENCY - 1;

   logic [PTR_W-1:0]      ptr_reg;
   logic [NUM_REQ-1:0]    grant;
   logic [PTR_W-1:0]      grant_id;
   logic                  accept;
   logic [PTR_W:0]        scan_sum;
   logic [PTR_W-1:0]      scan_idx;
   logic [ADDR_WIDTH-1:0] sel_addr;

   logic                  mem_valid_reg;
   logic [ADDR_WIDTH-1:0] mem_addr_reg;
   logic [NUM_REQ-1:0]    mem_tag_reg;
   logic                  err_reg;
   logic [GUARD_W-1:0]    guard_reg;
   logic                  tag_err;

   logic                  tag_valid_reg [READ_LATENCY];
   logic [NUM_REQ-1:0]    tag_id_reg    [READ_LATENCY];

   // Scan from the round-robin pointer; the first requesting index wins.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      accept   = 1'b0;
      scan_sum = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
         if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
            scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
         end
         scan_idx = scan_sum[PTR_W-1:0];
         if (!accept && !rst_in && bus.req_valid_in[scan_idx]) begin
            accept           = 1'b1;
            grant[scan_idx]  = 1'b1;
            grant_id         = scan_idx;
         end
      end
   end

   assign sel_addr          = bus.req_addr_in[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
   assign bus.req_ready_out = grant;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ptr_reg       <= '0;
         mem_valid_reg <= 1'b0;
         mem_addr_reg  <= '0;
         mem_tag_reg   <= '0;
         err_reg       <= 1'b0;
         guard_reg     <= GUARD_W'(READ_LATENCY);
      end else begin
         if (accept) begin
            ptr_reg       <= (grant_id == PTR_W'(NUM_REQ - 1)) ? '0 : grant_id + PTR_W'(1);
            mem_valid_reg <= 1'b1;
            mem_addr_reg  <= sel_addr;
            mem_tag_reg   <= grant;
         end else begin
            mem_valid_reg <= 1'b0;
         end
         if (guard_reg != '0) begin
            guard_reg <= guard_reg - GUARD_W'(1);
         end
         if (tag_err) begin
            err_reg <= 1'b1;
         end
      end
   end

   // Tags travel alongside the read so the returning word needs no address match.
   genvar gi;
   generate
      for (gi = 0; gi < READ_LATENCY; gi++) begin : g_tag
         if (gi == 0) begin : g_head
            always_ff @(posedge clk_in) begin
               if (rst_in) begin
                  tag_valid_reg[gi] <= 1'b0;
                  tag_id_reg[gi]    <= '0;
               end else begin
                  tag_valid_reg[gi] <= mem_valid_reg;
                  tag_id_reg[gi]    <= mem_tag_reg;
               end
            end
         end else begin : g_body
            always_ff @(posedge clk_in) begin
               if (rst_in) begin
                  tag_valid_reg[gi] <= 1'b0;
                  tag_id_reg[gi]    <= '0;
               end else begin
                  tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                  tag_id_reg[gi]    <= tag_id_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   // Stale returns from reads issued before reset are ignored until the guard window drains.
   assign tag_err = (bus.mem_valid_in != tag_valid_reg[TAIL]) && (guard_reg == '0);

   assign bus.rsp_valid_out = (rst_in || !tag_valid_reg[TAIL]) ? '0
                              : (tag_id_reg[TAIL] & {NUM_REQ{bus.mem_valid_in}});
   assign bus.rsp_data_out  = rst_in ? '0 : bus.mem_data_in;
   assign bus.mem_valid_out = mem_valid_reg;
   assign bus.mem_addr_out  = mem_addr_reg;
   assign bus.proto_err_out = err_reg;

`ifdef MEM_ARB_PERF_EN
   logic [15:0] grant_cnt_reg [NUM_REQ];

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
         always_ff @(posedge clk_in) begin
            if (rst_in) begin
               grant_cnt_reg[gi] <= '0;
            end else if (grant[gi] && grant_cnt_reg[gi] != 16'hFFFF) begin
               grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 16'd1;
            end
         end
         assign bus.grant_count_out[gi*16 +: 16] = grant_cnt_reg[gi];
      end
   endgenerate
`endif

endmodule
